// File: rtl/pwm_pattern_array.sv
// -----------------------------------------------------------------------------
// pwm_pattern_array
//
// N-channel pattern-PWM engine. Each channel holds shadow configuration
// written through a simple register port. A group start copies the shadow
// registers of the selected idle channels into their active registers. Each
// started channel then waits out its own phase delay and serialises its
// pattern MSB first. Every pattern bit lasts bit_len+1 cycles, and bursts are
// separated by an optional low gap. A channel completes after 'bursts'
// bursts, or never when bursts is 0.
//
// Optional feature macro: PWM_ARRAY_INVERT_EN
//   When defined, cfg_sel=5 writes a per-channel invert bit. The invert bit is
//   latched at start and XORed onto the waveform while the channel is busy;
//   an idle channel drives the shadow invert level. When undefined there is
//   no invert storage, cfg_sel=5 writes are ignored and idle/gap levels are 0.
//
// Ports
//   clk          single clock
//   rst          synchronous active-high reset
//   cfg_we       shadow register write strobe
//   cfg_ch       target channel (values >= NUM_CH are ignored)
//   cfg_sel      0 PAT, 1 bit_len, 2 gap, 3 bursts, 4 phase, 5 invert
//   cfg_data     write data, LSB aligned, truncated to the register width
//   start        group start pulse, qualified per channel by start_mask
//   stop         group abort pulse, qualified per channel by stop_mask
//   done_clr     write-1-clear of done_sticky
//   pwm_out      registered PWM outputs
//   busy         channel active
//   valid        one-cycle pulse on normal completion
//   done_sticky  latched completion flags
//   irq          registered OR of done_sticky
// -----------------------------------------------------------------------------
module pwm_pattern_array #(
    parameter int NUM_CH    = 8,
    parameter int PAT_WIDTH = 16,
    parameter int CNT_WIDTH = 16,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [2:0]           cfg_sel,
    input  logic [31:0]          cfg_data,
    input  logic                 start,
    input  logic [NUM_CH-1:0]    start_mask,
    input  logic                 stop,
    input  logic [NUM_CH-1:0]    stop_mask,
    input  logic [NUM_CH-1:0]    done_clr,
    output logic [NUM_CH-1:0]    pwm_out,
    output logic [NUM_CH-1:0]    busy,
    output logic [NUM_CH-1:0]    valid,
    output logic [NUM_CH-1:0]    done_sticky,
    output logic                 irq
);

    localparam int IDX_W = $clog2(PAT_WIDTH);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PHASE = 2'd1,
        ST_BIT   = 2'd2,
        ST_GAP   = 2'd3
    } ch_state_t;

    // Upper cfg_data bits are legitimately dropped by the truncating writes.
    logic unused_cfg_s;
    assign unused_cfg_s = ^cfg_data;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        // Shadow (host-visible) configuration
        logic [PAT_WIDTH-1:0] sh_pat_r;
        logic [7:0]           sh_len_r;
        logic [CNT_WIDTH-1:0] sh_gap_r;
        logic [7:0]           sh_bursts_r;
        logic [CNT_WIDTH-1:0] sh_phase_r;

        // Active configuration, frozen for the duration of a run
        logic [PAT_WIDTH-1:0] act_pat_r,    act_pat_s;
        logic [7:0]           act_len_r,    act_len_s;
        logic [CNT_WIDTH-1:0] act_gap_r,    act_gap_s;
        logic [7:0]           act_bursts_r, act_bursts_s;

`ifdef PWM_ARRAY_INVERT_EN
        logic                 sh_inv_r;
        logic                 act_inv_r,    act_inv_s;
`endif

        // Sequencer state and counters; cnt is shared by PHASE and GAP
        ch_state_t            state_r,      state_s;
        logic [CNT_WIDTH-1:0] cnt_r,        cnt_s;
        logic [IDX_W-1:0]     bit_idx_r,    bit_idx_s;
        logic [7:0]           len_cnt_r,    len_cnt_s;
        logic [7:0]           burst_cnt_r,  burst_cnt_s;

        // Registered outputs
        logic                 pwm_r,   pwm_s;
        logic                 busy_r,  busy_s;
        logic                 valid_r, valid_s;
        logic                 done_r,  done_s;

        logic                 start_s;
        logic                 stop_s;
        logic                 burst_end_s;
        logic                 done_set_s;
        logic                 wave_s;

        assign start_s = start & start_mask[gi];
        assign stop_s  = stop & stop_mask[gi];

        // Shadow register write port
        always_ff @(posedge clk) begin
            if (rst) begin
                sh_pat_r    <= {PAT_WIDTH{1'b0}};
                sh_len_r    <= 8'd0;
                sh_gap_r    <= {CNT_WIDTH{1'b0}};
                sh_bursts_r <= 8'd1;
                sh_phase_r  <= {CNT_WIDTH{1'b0}};
`ifdef PWM_ARRAY_INVERT_EN
                sh_inv_r    <= 1'b0;
`endif
            end else if (cfg_we && (cfg_ch == CH_W'(gi))) begin
                case (cfg_sel)
                    3'd0:    sh_pat_r    <= cfg_data[PAT_WIDTH-1:0];
                    3'd1:    sh_len_r    <= cfg_data[7:0];
                    3'd2:    sh_gap_r    <= cfg_data[CNT_WIDTH-1:0];
                    3'd3:    sh_bursts_r <= cfg_data[7:0];
                    3'd4:    sh_phase_r  <= cfg_data[CNT_WIDTH-1:0];
`ifdef PWM_ARRAY_INVERT_EN
                    3'd5:    sh_inv_r    <= cfg_data[0];
`endif
                    default: ;
                endcase
            end
        end

        // Channel sequencer next-state and output computation
        always_comb begin
            state_s      = state_r;
            cnt_s        = cnt_r;
            bit_idx_s    = bit_idx_r;
            len_cnt_s    = len_cnt_r;
            burst_cnt_s  = burst_cnt_r;
            act_pat_s    = act_pat_r;
            act_len_s    = act_len_r;
            act_gap_s    = act_gap_r;
            act_bursts_s = act_bursts_r;
`ifdef PWM_ARRAY_INVERT_EN
            act_inv_s    = act_inv_r;
`endif
            burst_end_s  = 1'b0;
            done_set_s   = 1'b0;
            valid_s      = 1'b0;
            wave_s       = 1'b0;

            if (stop_s) begin
                // Abort outranks everything, including a coincident start.
                state_s = ST_IDLE;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (start_s) begin
                            act_pat_s    = sh_pat_r;
                            act_len_s    = sh_len_r;
                            act_gap_s    = sh_gap_r;
                            act_bursts_s = sh_bursts_r;
`ifdef PWM_ARRAY_INVERT_EN
                            act_inv_s    = sh_inv_r;
`endif
                            burst_cnt_s  = 8'd0;
                            len_cnt_s    = 8'd0;
                            bit_idx_s    = IDX_MSB;
                            if (sh_phase_r != CNT_WIDTH'(0)) begin
                                state_s = ST_PHASE;
                                cnt_s   = sh_phase_r;
                            end else begin
                                state_s = ST_BIT;
                            end
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end
                    ST_PHASE: begin
                        // cnt counts phase..1, giving exactly 'phase' cycles
                        if (cnt_r == CNT_WIDTH'(1)) begin
                            state_s = ST_BIT;
                        end else begin
                            cnt_s = cnt_r - CNT_WIDTH'(1);
                        end
                    end
                    ST_BIT: begin
                        if (len_cnt_r == act_len_r) begin
                            len_cnt_s = 8'd0;
                            if (bit_idx_r == IDX_W'(0)) begin
                                bit_idx_s = IDX_MSB;
                                if (act_gap_r != CNT_WIDTH'(0)) begin
                                    state_s = ST_GAP;
                                    cnt_s   = act_gap_r;
                                end else begin
                                    burst_end_s = 1'b1;
                                end
                            end else begin
                                bit_idx_s = bit_idx_r - IDX_W'(1);
                            end
                        end else begin
                            len_cnt_s = len_cnt_r + 8'd1;
                        end
                    end
                    ST_GAP: begin
                        if (cnt_r == CNT_WIDTH'(1)) begin
                            burst_end_s = 1'b1;
                        end else begin
                            cnt_s = cnt_r - CNT_WIDTH'(1);
                        end
                    end
                    default: begin
                        state_s = ST_IDLE;
                    end
                endcase

                // A zero burst limit never matches, so the 8-bit counter
                // simply wraps and the channel runs until stopped.
                if (burst_end_s) begin
                    burst_cnt_s = burst_cnt_r + 8'd1;
                    if ((act_bursts_r != 8'd0) && (burst_cnt_s == act_bursts_r)) begin
                        state_s    = ST_IDLE;
                        valid_s    = 1'b1;
                        done_set_s = 1'b1;
                    end else begin
                        state_s = ST_BIT;
                    end
                end else begin
                    valid_s = 1'b0;
                end
            end

            // Set has priority over a coincident clear.
            if (done_set_s) begin
                done_s = 1'b1;
            end else if (done_clr[gi]) begin
                done_s = 1'b0;
            end else begin
                done_s = done_r;
            end

            busy_s = (state_s != ST_IDLE);

            if (state_s == ST_BIT) begin
                wave_s = act_pat_s[bit_idx_s];
            end else begin
                wave_s = 1'b0;
            end

`ifdef PWM_ARRAY_INVERT_EN
            if (busy_s) begin
                pwm_s = wave_s ^ act_inv_s;
            end else begin
                pwm_s = sh_inv_r;
            end
`else
            pwm_s = wave_s;
`endif
        end

        // Channel sequencer and output registers
        always_ff @(posedge clk) begin
            if (rst) begin
                state_r      <= ST_IDLE;
                cnt_r        <= {CNT_WIDTH{1'b0}};
                bit_idx_r    <= IDX_MSB;
                len_cnt_r    <= 8'd0;
                burst_cnt_r  <= 8'd0;
                act_pat_r    <= {PAT_WIDTH{1'b0}};
                act_len_r    <= 8'd0;
                act_gap_r    <= {CNT_WIDTH{1'b0}};
                act_bursts_r <= 8'd1;
`ifdef PWM_ARRAY_INVERT_EN
                act_inv_r    <= 1'b0;
`endif
                pwm_r        <= 1'b0;
                busy_r       <= 1'b0;
                valid_r      <= 1'b0;
                done_r       <= 1'b0;
            end else begin
                state_r      <= state_s;
                cnt_r        <= cnt_s;
                bit_idx_r    <= bit_idx_s;
                len_cnt_r    <= len_cnt_s;
                burst_cnt_r  <= burst_cnt_s;
                act_pat_r    <= act_pat_s;
                act_len_r    <= act_len_s;
                act_gap_r    <= act_gap_s;
                act_bursts_r <= act_bursts_s;
`ifdef PWM_ARRAY_INVERT_EN
                act_inv_r    <= act_inv_s;
`endif
                pwm_r        <= pwm_s;
                busy_r       <= busy_s;
                valid_r      <= valid_s;
                done_r       <= done_s;
            end
        end

        assign pwm_out[gi]     = pwm_r;
        assign busy[gi]        = busy_r;
        assign valid[gi]       = valid_r;
        assign done_sticky[gi] = done_r;
    end

    // Interrupt register, one cycle behind the sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= |done_sticky;
        end
    end

endmodule

// File: tb/tb_pwm_pattern_array.sv
// -----------------------------------------------------------------------------
// tb_pwm_pattern_array
//
// Directed self-checking bench for pwm_pattern_array (default parameters:
// 8 channels, 16-bit patterns, 16-bit counters, invert feature disabled).
// Inputs are driven on the falling edge and outputs sampled on the falling
// edge, so "T+1" is the first falling edge after the start edge.
// -----------------------------------------------------------------------------
module tb_pwm_pattern_array;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [2:0]  cfg_ch;
    logic [2:0]  cfg_sel;
    logic [31:0] cfg_data;
    logic        start;
    logic [7:0]  start_mask;
    logic        stop;
    logic [7:0]  stop_mask;
    logic [7:0]  done_clr;
    logic [7:0]  pwm_out;
    logic [7:0]  busy;
    logic [7:0]  valid;
    logic [7:0]  done_sticky;
    logic        irq;

    int n_assert = 0;
    int n_fail   = 0;

    pwm_pattern_array #(
        .NUM_CH    (8),
        .PAT_WIDTH (16),
        .CNT_WIDTH (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_sel     (cfg_sel),
        .cfg_data    (cfg_data),
        .start       (start),
        .start_mask  (start_mask),
        .stop        (stop),
        .stop_mask   (stop_mask),
        .done_clr    (done_clr),
        .pwm_out     (pwm_out),
        .busy        (busy),
        .valid       (valid),
        .done_sticky (done_sticky),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [2:0] ch, input logic [2:0] sel, input logic [31:0] data);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_ch   = ch;
        cfg_sel  = sel;
        cfg_data = data;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    // Returns at the T+1 sample point.
    task automatic pulse_start(input logic [7:0] mask);
        @(negedge clk);
        start      = 1'b1;
        start_mask = mask;
        @(negedge clk);
        start      = 1'b0;
        start_mask = 8'h00;
    endtask

    task automatic clear_done();
        @(negedge clk);
        done_clr = 8'hFF;
        @(negedge clk);
        done_clr = 8'h00;
    endtask

    initial begin
        logic [63:0] v_a;
        logic [63:0] v_b;
        logic [63:0] v_c;
        logic [63:0] v_d;
        int          bcnt;
        int          hcnt;
        int          vcnt;

        rst = 1'b1; cfg_we = 1'b0; cfg_ch = 3'd0; cfg_sel = 3'd0; cfg_data = 32'd0;
        start = 1'b0; start_mask = 8'h00; stop = 1'b0; stop_mask = 8'h00; done_clr = 8'h00;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", {29'd0, pwm_out, busy, valid, done_sticky, irq}, 64'd0);

        // ---------------- single burst, ch0 A5A5, bit_len 1 ----------------
        cfg_write(3'd0, 3'd0, 32'h0000_A5A5);
        cfg_write(3'd0, 3'd1, 32'd1);
        pulse_start(8'h01);
        v_a = 64'd0; bcnt = 0; vcnt = 0;
        for (int k = 0; k < 32; k++) begin
            v_a  = {v_a[62:0], pwm_out[0]};
            bcnt += int'(busy[0]);
            vcnt += int'(valid[0]);
            @(negedge clk);
        end
        check("single_waveform", v_a, 64'h0000_0000_CC33_CC33);
        check("single_busy_len", 64'(bcnt), 64'd32);
        check("single_no_early_valid", 64'(vcnt), 64'd0);
        check("single_valid_T33", {63'd0, valid[0]}, 64'd1);
        check("single_busy_low_T33", {56'd0, busy}, 64'd0);
        check("single_done_T33", {56'd0, done_sticky}, 64'h01);
        check("single_irq_lag_T33", {63'd0, irq}, 64'd0);
        @(negedge clk);
        check("single_valid_one_cycle", {56'd0, valid}, 64'd0);
        check("single_irq_T34", {63'd0, irq}, 64'd1);
        clear_done();
        check("done_clr_clears", {56'd0, done_sticky}, 64'd0);
        @(negedge clk);
        check("irq_follows_clear", {63'd0, irq}, 64'd0);

        // ---------------- phase-aligned group start ----------------
        cfg_write(3'd1, 3'd0, 32'h0000_F00F);
        cfg_write(3'd1, 3'd4, 32'd5);
        cfg_write(3'd2, 3'd0, 32'h0000_F00F);
        pulse_start(8'h06);
        v_a = 64'd0; v_b = 64'd0; v_c = 64'd0; v_d = 64'd0;
        for (int k = 0; k < 30; k++) begin
            v_a = {v_a[62:0], pwm_out[1]};
            v_b = {v_b[62:0], pwm_out[2]};
            v_c = {v_c[62:0], valid[1]};
            v_d = {v_d[62:0], valid[2]};
            @(negedge clk);
        end
        check("phase_ch2_wave", v_b, 64'h0000_0000_3C03_C000);
        check("phase_ch1_wave", v_a, 64'h0000_0000_01E0_1E00);
        check("phase_ch2_valid", v_d, 64'h0000_0000_0000_2000);
        check("phase_ch1_valid", v_c, 64'h0000_0000_0000_0100);
        check("phase_done", {56'd0, done_sticky}, 64'h06);
        clear_done();

        // ---------------- gap and bursts, ch3 ----------------
        cfg_write(3'd3, 3'd0, 32'h0000_8000);
        cfg_write(3'd3, 3'd2, 32'd4);
        cfg_write(3'd3, 3'd3, 32'd3);
        @(negedge clk);
        check("pre_gap_quiet", {55'd0, done_sticky, irq}, 64'd0);
        pulse_start(8'h08);
        v_a = 64'd0; v_b = 64'd0; v_c = 64'd0; v_d = 64'd0; bcnt = 0;
        for (int k = 0; k < 62; k++) begin
            v_a[k] = pwm_out[3];
            v_b[k] = valid[3];
            v_c[k] = done_sticky[3];
            v_d[k] = irq;
            bcnt  += int'(busy[3]);
            @(negedge clk);
        end
        check("gap_highs", v_a, 64'h0000_0100_0010_0001);
        check("gap_busy_len", 64'(bcnt), 64'd60);
        check("gap_valid", v_b, 64'h1000_0000_0000_0000);
        check("gap_done", v_c, 64'h3000_0000_0000_0000);
        check("gap_irq", v_d, 64'h2000_0000_0000_0000);
        clear_done();

        // ---------------- infinite run with abort, ch4 and ch5 ----------------
        cfg_write(3'd4, 3'd0, 32'h0000_FFFF);
        cfg_write(3'd4, 3'd3, 32'd0);
        cfg_write(3'd5, 3'd0, 32'h0000_FFFF);
        cfg_write(3'd5, 3'd3, 32'd0);
        pulse_start(8'h30);
        hcnt = 0; vcnt = 0;
        for (int k = 0; k < 1000; k++) begin
            hcnt += int'(pwm_out[4]);
            vcnt += int'(|valid);
            @(negedge clk);
        end
        check("inf_high_cycles", 64'(hcnt), 64'd1000);
        check("inf_no_valid", 64'(vcnt), 64'd0);
        stop = 1'b1; stop_mask = 8'h10;
        @(negedge clk);
        stop = 1'b0; stop_mask = 8'h00;
        check("stop_ch4_busy", {56'd0, busy}, 64'h20);
        check("stop_ch4_pwm", {56'd0, pwm_out}, 64'h20);
        check("stop_no_valid", {56'd0, valid}, 64'd0);
        check("stop_done_unchanged", {56'd0, done_sticky}, 64'd0);
        stop = 1'b1; stop_mask = 8'h20;
        @(negedge clk);
        stop = 1'b0; stop_mask = 8'h00;
        check("stop_ch5_idle", {48'd0, busy, pwm_out}, 64'd0);
        vcnt = 0;
        for (int k = 0; k < 5; k++) begin
            vcnt += int'(|valid);
            @(negedge clk);
        end
        check("stop_no_late_valid", 64'(vcnt), 64'd0);

        // ---------------- start while busy + shadow write during busy, ch6 ----------------
        cfg_write(3'd6, 3'd0, 32'h0000_FFFF);
        pulse_start(8'h40);
        hcnt = 0; bcnt = 0; v_a = 64'd0;
        for (int k = 0; k < 20; k++) begin
            hcnt  += int'(pwm_out[6]);
            bcnt  += int'(busy[6]);
            v_a[k] = valid[6];
            if (k == 4) begin
                start = 1'b1; start_mask = 8'h40;
                cfg_we = 1'b1; cfg_ch = 3'd6; cfg_sel = 3'd0; cfg_data = 32'h0000_0000;
            end else begin
                start = 1'b0; start_mask = 8'h00; cfg_we = 1'b0;
            end
            @(negedge clk);
        end
        check("busy_start_highs", 64'(hcnt), 64'd16);
        check("busy_start_len", 64'(bcnt), 64'd16);
        check("busy_start_valid", v_a, 64'h0000_0000_0001_0000);
        pulse_start(8'h40);
        hcnt = 0; bcnt = 0; v_a = 64'd0;
        for (int k = 0; k < 20; k++) begin
            hcnt  += int'(pwm_out[6]);
            bcnt  += int'(busy[6]);
            v_a[k] = valid[6];
            @(negedge clk);
        end
        check("new_pat_highs", 64'(hcnt), 64'd0);
        check("new_pat_len", 64'(bcnt), 64'd16);
        check("new_pat_valid", v_a, 64'h0000_0000_0001_0000);
        clear_done();

        // ---------------- stop and start on the same cycle, ch7 ----------------
        @(negedge clk);
        start = 1'b1; start_mask = 8'h80; stop = 1'b1; stop_mask = 8'h80;
        @(negedge clk);
        start = 1'b0; start_mask = 8'h00; stop = 1'b0; stop_mask = 8'h00;
        bcnt = 0; vcnt = 0;
        for (int k = 0; k < 20; k++) begin
            bcnt += int'(busy[7]);
            vcnt += int'(valid[7]);
            @(negedge clk);
        end
        check("stop_start_busy", 64'(bcnt), 64'd0);
        check("stop_start_valid", 64'(vcnt), 64'd0);

        // ---------------- done_clr coinciding with completion, ch0 ----------------
        pulse_start(8'h01);
        repeat (31) @(negedge clk);
        done_clr = 8'h01;
        @(negedge clk);
        done_clr = 8'h00;
        check("coincide_valid", {56'd0, valid}, 64'h01);
        check("coincide_done_kept", {56'd0, done_sticky}, 64'h01);
        @(negedge clk);
        check("coincide_irq", {63'd0, irq}, 64'd1);

        // ---------------- reset mid-sequence ----------------
        pulse_start(8'h09);
        repeat (3) @(negedge clk);
        check("pre_reset_busy", {56'd0, busy}, 64'h09);
        rst = 1'b1;
        @(negedge clk);
        check("mid_reset_outputs", {29'd0, pwm_out, busy, valid, done_sticky, irq}, 64'd0);
        rst = 1'b0;
        pulse_start(8'h09);
        hcnt = 0; bcnt = 0; v_a = 64'd0;
        for (int k = 0; k < 20; k++) begin
            hcnt  += int'(|pwm_out);
            bcnt  += int'(busy == 8'h09);
            v_a[k] = (valid == 8'h09);
            @(negedge clk);
        end
        check("post_reset_low", 64'(hcnt), 64'd0);
        check("post_reset_len", 64'(bcnt), 64'd16);
        check("post_reset_valid", v_a, 64'h0000_0000_0001_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_pattern_array.md
# pwm_pattern_array

Parametrised N-channel pattern-PWM engine, the generalised successor to the fixed four-instance pattern-PWM arrangement in the DDS sample top level. It holds per-channel shadow configuration written over a simple register port, e.g. from the UART register mapper. Masked channels start on the same clock, each after its own phase delay. Every channel serialises a bit pattern with a programmable bit length, inter-burst gap and burst count, and reports busy, done and a sticky interrupt.

## Interface
- NUM_CH, 8, channel count (1–32)
- PAT_WIDTH, 16, pattern length in bits (2–32)
- CNT_WIDTH, 16, width of the gap and phase counters
- clk  in  1  single clock for all logic
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  shadow register write strobe
- cfg_ch  in  $clog2(NUM_CH)  target channel; values ≥ NUM_CH are ignored
- cfg_sel  in  3  register select: 0 PAT, 1 bit_len, 2 gap, 3 bursts, 4 phase, 5 invert
- cfg_data  in  32  write data, LSB-aligned and truncated to the register width
- start  in  1  group start pulse
- start_mask  in  NUM_CH  channels affected by start
- stop  in  1  group abort pulse
- stop_mask  in  NUM_CH  channels affected by stop
- done_clr  in  NUM_CH  write-1-clear for done_sticky
- pwm_out  out  NUM_CH  registered PWM outputs
- busy  out  NUM_CH  channel active
- valid  out  NUM_CH  one-cycle pulse on normal completion
- done_sticky  out  NUM_CH  latched completion flags
- irq  out  1  OR of done_sticky, registered

## Operation
- Shadow registers per channel and their reset values:
  - PAT[PAT_WIDTH-1:0] = 0
  - bit_len[7:0] = 0; each bit lasts bit_len+1 cycles
  - gap[CNT_WIDTH-1:0] = 0
  - bursts[7:0] = 1; 0 means infinite
  - phase[CNT_WIDTH-1:0] = 0
- Shadow writes take effect at the next start of that channel. Writes while busy never disturb the running sequence.
- Start: for channel i, start & start_mask[i] & !busy[i] copies the shadow registers to the active registers.
- Start while busy: the start is ignored for that channel. The sequence is not restarted.
- Per-channel FSM: IDLE → PHASE (skipped if phase=0) → BIT → GAP (skipped if gap=0) → BIT … → IDLE.
  - BIT: PAT is output MSB first. A bit counter and a length counter advance the pattern.
  - After the LSB, the FSM enters GAP, with pwm_out low.
  - At the end of GAP the burst counter increments. If it equals bursts (bursts≠0), the FSM returns to IDLE. Otherwise it returns to BIT at the MSB.
  - The burst counter is 8-bit. With bursts=0 it wraps freely and the channel never self-terminates.
- Stop: stop & stop_mask[i] forces IDLE on the next edge with pwm_out low and busy low. No valid pulse is generated.
- Stop and start on the same cycle for the same channel: stop wins and the channel stays IDLE.
- Completion: on the IDLE transition, valid[i] pulses for exactly one cycle and done_sticky[i] is set.
- done_clr[i] clears done_sticky[i]. If set and clear coincide, set wins.
- Reset at any time:
  - all outputs go to 0 on the next edge;
  - all FSMs return to IDLE;
  - shadow and active registers return to their reset values.

## Timing
- All outputs are registered. The start cycle is T.
- Cycle T+1: busy=1.
- The first pattern bit appears on pwm_out at T+1+phase.
- Busy stays high for exactly phase + bursts·(PAT_WIDTH·(bit_len+1) + gap) cycles.
- valid pulses on the first cycle busy is low again.
- irq follows done_sticky by one cycle.
- Channels started by the same start pulse with equal configuration produce cycle-identical pwm_out.
- A stop at cycle S gives busy=0 and pwm_out=0 at S+1.
- A cfg_we at cycle W is visible to a start at W+1 or later.

## Configuration
- PWM_ARRAY_INVERT_EN defined:
  - cfg_sel=5 writes invert[i] = cfg_data[0];
  - the active copy is latched at start;
  - pwm_out[i] = active waveform XOR invert while busy, and the idle level equals invert.
- PWM_ARRAY_INVERT_EN undefined:
  - no invert storage exists;
  - cfg_sel=5 writes are ignored;
  - idle and gap levels are always 0.

## Test plan
- Single burst: ch0 with PAT=16'hA5A5, bit_len=1, gap=0, bursts=1, phase=0, then start → busy for 32 cycles. pwm_out shows 1,1,0,0,1,1,0,0,… and valid pulses once at T+33.
- Phase-aligned group start: ch1 phase=5, ch2 phase=0, identical patterns, start_mask=0b0110 → ch1 waveform lags ch2 by exactly 5 cycles and its valid also lags by 5.
- Gap and bursts: PAT=16'h8000, bit_len=0, gap=4, bursts=3 → three 1-cycle highs 20 cycles apart, busy for 60 cycles, done_sticky set, irq high one cycle later.
- Infinite run with abort: bursts=0, run 1000 cycles, then stop with the matching mask → busy=0 and pwm_out=0 next cycle, no valid pulse, done_sticky unchanged.
- Edge cases:
  - start while busy is ignored;
  - stop and start on the same cycle leave the channel idle;
  - a shadow write of PAT during busy does not alter the current output but appears on the next start;
  - done_clr coinciding with valid leaves done_sticky=1.
- Reset mid-sequence:
  - assert rst during BIT → all outputs 0 next edge;
  - after release, start with no writes → bursts=1 and PAT=0 give low output for PAT_WIDTH cycles, then a valid pulse.
